// File: rtl/alu_op_sequencer.sv
// Loads opcode/A/B byte beats into registers driving a combinational ALU, then registers result+flags (ALU_SEQ_ACC_CHAIN_EN adds a 2-beat accumulate chain).
// Latency: B beat on edge N -> out_valid after edge N+1; next opcode beat accepted no earlier than edge N+3.
// Backpressure: in_ready low in EXEC/RESP; RESP holds until out_ready; a stalled load aborts after TIMEOUT idle cycles.
module alu_op_sequencer #(
    parameter int unsigned DATA_W  = 7,
    parameter int unsigned OP_W    = 3,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_opsel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_ovf,
    input  logic              alu_zero,
    input  logic              alu_neg,
    output logic [DATA_W-1:0] out_result,
    output logic [3:0]        out_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              timeout_pulse
);

    typedef enum logic [2:0] {
        LOAD_OP = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        EXEC    = 3'd3,
        RESP    = 3'd4
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [3:0]        flags;
    } resp_t;

    localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);
    localparam bit         TIMEOUT_EN  = (TIMEOUT != 0);

    state_t      state_q, state_d;
    resp_t       resp_q;
    logic [7:0]  idle_cnt_q, idle_cnt_d;
    logic [8:0]  idle_inc;
    logic        timeout_pulse_d;
    logic        beat_hs;
    logic        loading;
    logic        timeout_hit;
    logic        chain_beat;
    logic        unused_in_msb;

    // Bit 7 of every beat is reserved.
    assign unused_in_msb = in_data[7];

`ifdef ALU_SEQ_ACC_CHAIN_EN
    assign chain_beat = in_data[3];
`else
    assign chain_beat = 1'b0;
`endif

    assign loading  = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign in_ready = (state_q == LOAD_OP) || loading;
    assign beat_hs  = in_valid && in_ready;
    assign idle_inc = {1'b0, idle_cnt_q} + 9'd1;

    // Abort on the idle edge that brings the count up to TIMEOUT; a beat on that edge wins.
    assign timeout_hit = TIMEOUT_EN && loading && !beat_hs && (idle_inc == TIMEOUT_LIM);

    always_comb begin
        state_d         = state_q;
        idle_cnt_d      = idle_cnt_q;
        timeout_pulse_d = 1'b0;
        case (state_q)
            LOAD_OP: begin
                idle_cnt_d = 8'd0;
                if (beat_hs) begin
                    state_d = chain_beat ? LOAD_B : LOAD_A;
                end
            end
            LOAD_A, LOAD_B: begin
                if (beat_hs) begin
                    idle_cnt_d = 8'd0;
                    state_d    = (state_q == LOAD_A) ? LOAD_B : EXEC;
                end else if (timeout_hit) begin
                    idle_cnt_d      = 8'd0;
                    state_d         = LOAD_OP;
                    timeout_pulse_d = 1'b1;
                end else if (idle_cnt_q != 8'hFF) begin
                    idle_cnt_d = idle_inc[7:0];
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (out_ready) begin
                    state_d = LOAD_OP;
                end
            end
            default: begin
                state_d    = LOAD_OP;
                idle_cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= LOAD_OP;
            idle_cnt_q    <= 8'd0;
            timeout_pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            idle_cnt_q    <= idle_cnt_d;
            timeout_pulse <= timeout_pulse_d;
        end
    end

    // ALU operand registers move only on an accepted beat, so the ALU sees stable inputs through EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opsel <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
        end else if (beat_hs) begin
            case (state_q)
                LOAD_OP: begin
                    alu_opsel <= in_data[OP_W-1:0];
                    if (chain_beat) begin
                        alu_a <= resp_q.result;
                    end
                end
                LOAD_A:  alu_a <= in_data[DATA_W-1:0];
                LOAD_B:  alu_b <= in_data[DATA_W-1:0];
                default: ;
            endcase
        end
    end

    // Result register holds after out_valid drops; it also feeds the accumulate chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q <= '0;
        end else if (state_q == EXEC) begin
            resp_q.result <= alu_result;
            resp_q.flags  <= {alu_neg, alu_zero, alu_ovf, alu_carry};
        end
    end

    assign out_result = resp_q.result;
    assign out_flags  = resp_q.flags;
    assign out_valid  = (state_q == RESP);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 7-bit ALU and an expected-result queue.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] alu_a, alu_b;
    logic [2:0] alu_opsel;
    logic [6:0] alu_result;
    logic       alu_carry, alu_ovf, alu_zero, alu_neg;
    logic [6:0] out_result;
    logic [3:0] out_flags;
    logic       out_valid;
    logic       out_ready;
    logic       timeout_pulse;

    int tests = 0;
    int fails = 0;
    logic [10:0] sb[$];

    always #5 clk = ~clk;

    alu_op_sequencer #(.DATA_W(7), .OP_W(3), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opsel(alu_opsel),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
        .alu_zero(alu_zero), .alu_neg(alu_neg),
        .out_result(out_result), .out_flags(out_flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .timeout_pulse(timeout_pulse)
    );

    // Stand-in ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not, 11x zero.
    logic [7:0] alu_wide;
    logic       alu_v;
    always_comb begin
        alu_wide = 8'd0;
        alu_v    = 1'b0;
        case (alu_opsel)
            3'b000: begin
                alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
                alu_v    = (alu_a[6] == alu_b[6]) && (alu_wide[6] != alu_a[6]);
            end
            3'b001: begin
                alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
                alu_v    = (alu_a[6] != alu_b[6]) && (alu_wide[6] != alu_a[6]);
            end
            3'b010:  alu_wide = {1'b0, alu_a & alu_b};
            3'b011:  alu_wide = {1'b0, alu_a | alu_b};
            3'b100:  alu_wide = {1'b0, alu_a ^ alu_b};
            3'b101:  alu_wide = {1'b0, ~alu_a};
            default: alu_wide = 8'd0;
        endcase
    end
    assign alu_result = alu_wide[6:0];
    assign alu_carry  = alu_wide[7];
    assign alu_ovf    = alu_v;
    assign alu_zero   = (alu_wide[6:0] == 7'd0);
    assign alu_neg    = alu_wide[6];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge with in_valid low.
    task automatic send_beat(input logic [7:0] b);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("beat_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        send_beat(op);
        send_beat(a);
        send_beat(b);
    endtask

    task automatic push_exp(input logic [6:0] res, input logic [3:0] flg);
        sb.push_back({res, flg});
    endtask

    task automatic expect_resp(input string tag);
        int n = 0;
        logic [10:0] e;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_result"}, out_result, e[10:4]);
            check({tag, "_flags"}, out_flags, e[3:0]);
        end
    endtask

    task automatic release_resp(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_opsel", alu_opsel, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_flags", out_flags, 0);
        check("rst_tpulse", timeout_pulse, 0);

        // 0x3F + 0x01: neg and overflow, with exact EXEC latency
        push_exp(7'h40, 4'b1010);
        run_op(8'h00, 8'h3F, 8'h01);
        check("lat_exec_valid", out_valid, 0);
        check("lat_exec_ready", in_ready, 0);
        check("lat_alu_a", alu_a, 7'h3F);
        check("lat_alu_b", alu_b, 7'h01);
        @(negedge clk);
        check("lat_resp_valid", out_valid, 1);
        expect_resp("add_ovf");
        release_resp("add_ovf");

        // 0x7F + 0x01: wraps to zero with carry
        push_exp(7'h00, 4'b0101);
        run_op(8'h00, 8'h7F, 8'h01);
        expect_resp("add_carry");
        release_resp("add_carry");

        // AND with reserved opcode bits and bit 7 of A set
        push_exp(7'h0A, 4'b0000);
        run_op(8'h12, 8'hDA, 8'h0F);
        check("and_opsel", alu_opsel, 3'b010);
        check("and_a_bit7", alu_a, 7'h5A);
        expect_resp("and");
        release_resp("and");

        // Opcode 110 passes through; ALU gives zero
        push_exp(7'h00, 4'b0100);
        run_op(8'h06, 8'h11, 8'h22);
        check("op6_opsel", alu_opsel, 3'b110);
        expect_resp("op6");
        release_resp("op6");

        // Hold RESP for 5 cycles with in_valid asserted
        out_ready = 1'b0;
        push_exp(7'h60, 4'b1001);
        run_op(8'h01, 8'h10, 8'h30);
        expect_resp("hold");
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_result", out_result, 7'h60);
        end
        in_valid = 1'b0;
        release_resp("hold");
        check("hold_result_after", out_result, 7'h60);
        check("hold_flags_after", out_flags, 4'b1001);

        // Timeout after opcode and A, then in_valid low
        send_beat(8'h01);
        send_beat(8'h33);
        check("to_idle0", timeout_pulse, 0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("to_idle_pulse", timeout_pulse, 0);
            check("to_idle_ready", in_ready, 1);
        end
        @(negedge clk);
        check("to_pulse", timeout_pulse, 1);
        check("to_ready", in_ready, 1);
        check("to_alu_a_kept", alu_a, 7'h33);
        check("to_opsel_kept", alu_opsel, 3'b001);
        @(negedge clk);
        check("to_pulse_drop", timeout_pulse, 0);
        push_exp(7'h03, 4'b0000);
        run_op(8'h00, 8'h01, 8'h02);
        check("to_next_opsel", alu_opsel, 3'b000);
        expect_resp("after_to");
        release_resp("after_to");

        // Asynchronous reset while waiting for B
        send_beat(8'h00);
        send_beat(8'h44);
        #2 rst_n = 1'b0;
        #1;
        check("rstb_alu_a", alu_a, 0);
        check("rstb_out_result", out_result, 0);
        check("rstb_out_valid", out_valid, 0);
        check("rstb_tpulse", timeout_pulse, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstb_in_ready", in_ready, 1);

        // Asynchronous reset in RESP
        out_ready = 1'b0;
        push_exp(7'h40, 4'b1010);
        run_op(8'h00, 8'h20, 8'h20);
        expect_resp("pre_rst_resp");
        #2 rst_n = 1'b0;
        #1;
        check("rstr_out_valid", out_valid, 0);
        check("rstr_out_result", out_result, 0);
        check("rstr_out_flags", out_flags, 0);
        check("rstr_alu_b", alu_b, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("rstr_in_ready", in_ready, 1);
        check("rstr_out_valid2", out_valid, 0);

        // Fresh operation after reset: 0x05 + 0x03
        push_exp(7'h08, 4'b0000);
        run_op(8'h00, 8'h05, 8'h03);
        expect_resp("fresh");
        release_resp("fresh");

        // Opcode beat with bit 3 set
`ifdef ALU_SEQ_ACC_CHAIN_EN
        send_beat(8'h08);
        check("chain_alu_a", alu_a, 7'h08);
        push_exp(7'h0A, 4'b0000);
        send_beat(8'h02);
        expect_resp("chain");
        release_resp("chain");
`else
        send_beat(8'h08);
        send_beat(8'h02);
        check("nochain_wait_b", in_ready, 1);
        check("nochain_no_valid", out_valid, 0);
        check("nochain_alu_a", alu_a, 7'h02);
        push_exp(7'h05, 4'b0000);
        send_beat(8'h03);
        expect_resp("nochain");
        release_resp("nochain");
`endif

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
